// File: rtl/sisc_pkg.sv
// Shared sisc definitions: address/data widths, reset PC and the fetch-state encoding.
package sisc_pkg;

  localparam int SISC_AW = 16;
  localparam int SISC_DW = 32;
  localparam logic [SISC_AW-1:0] SISC_RESET_PC = 16'h0000;

  typedef enum logic {
    IFQ_RUN   = 1'b0,
    IFQ_DRAIN = 1'b1
  } ifq_state_e;

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer of fetched {word, pc} entries with a synchronous clear used on redirects.
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 48
) (
  input  logic                     clk,
  input  logic                     rst_f,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // NOTE: storage has no reset; every reader qualifies the head with empty,
  // so stale contents after reset or clear are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: owns fetch_pc, issues single-outstanding memory reads,
// buffers words for the control unit. Define IFQ_BYPASS_EN for the same-cycle empty bypass.
module ifetch_queue
  import sisc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SISC_AW,
  parameter int DW    = SISC_DW
) (
  input  logic          clk,
  input  logic          rst_f,
  output logic          im_req,
  output logic [AW-1:0] im_addr,
  input  logic          im_ack,
  input  logic [DW-1:0] im_data,
  output logic          instr_valid,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  input  logic          instr_ready,
  input  logic          redir,
  input  logic [AW-1:0] redir_addr,
  output logic          ifq_empty,
  output logic          ifq_full
);

  ifq_state_e            state;
  logic [AW-1:0]         fetch_pc;
  logic [AW-1:0]         drain_addr;
  logic                  run_ack;
  logic                  bypass;
  logic                  push;
  logic                  pop;
  logic [DW+AW-1:0]      head;
  logic [$clog2(DEPTH):0] count;

  // Gating with rst_f keeps the request low for the whole reset, not just after the first edge.
  assign im_req  = !rst_f && ((state == IFQ_DRAIN) || !ifq_full);
  assign im_addr = (state == IFQ_DRAIN) ? drain_addr : fetch_pc;
  assign run_ack = (state == IFQ_RUN) && im_req && im_ack;

`ifdef IFQ_BYPASS_EN
  assign bypass = ifq_empty && run_ack && !redir;
`else
  assign bypass = 1'b0;
`endif

  assign push = run_ack && !redir && !(bypass && instr_ready);
  assign pop  = !ifq_empty && instr_ready && !redir;

  ifq_fifo #(
    .DEPTH (DEPTH),
    .W     (DW + AW)
  ) u_fifo (
    .clk   (clk),
    .rst_f (rst_f),
    .clr   (redir),
    .push  (push),
    .pop   (pop),
    .wdata ({im_data, fetch_pc}),
    .rdata (head),
    .count (count),
    .empty (ifq_empty),
    .full  (ifq_full)
  );

  assign instr_valid = !ifq_empty || bypass;
  assign instr       = !ifq_empty ? head[DW+AW-1:AW] : (bypass ? im_data  : '0);
  assign instr_pc    = !ifq_empty ? head[AW-1:0]     : (bypass ? fetch_pc : '0);

  // A redirect during an un-acked request parks the old address in drain_addr until its ack.
  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      state      <= IFQ_RUN;
      fetch_pc   <= AW'(SISC_RESET_PC);
      drain_addr <= AW'(SISC_RESET_PC);
    end else begin
      if (redir)        fetch_pc <= redir_addr;
      else if (run_ack) fetch_pc <= fetch_pc + 1'b1;

      case (state)
        IFQ_RUN: begin
          if (redir && im_req && !im_ack) begin
            state      <= IFQ_DRAIN;
            drain_addr <= fetch_pc;
          end
        end
        IFQ_DRAIN: begin
          if (im_ack) state <= IFQ_RUN;
        end
        default: state <= IFQ_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: a wait-state memory model, directed scenarios,
// and a negedge monitor that compares every pop against the expected queue.
module tb_ifetch_queue;
  import sisc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        im_req;
  logic [15:0] im_addr;
  logic        im_ack;
  logic [31:0] im_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic        redir;
  logic [15:0] redir_addr;
  logic        ifq_empty;
  logic        ifq_full;

  int errors = 0;
  int checks = 0;
  int pop_count = 0;
  int wait_states = 0;
  int age;
  int ack_count;

  typedef struct {
    logic [15:0] pc;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  ifetch_queue #(.DEPTH(4), .AW(16), .DW(32)) dut (
    .clk         (clk),
    .rst_f       (rst_f),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_ack      (im_ack),
    .im_data     (im_data),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redir       (redir),
    .redir_addr  (redir_addr),
    .ifq_empty   (ifq_empty),
    .ifq_full    (ifq_full)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  // Memory: acks once a request has been held for wait_states cycles.
  assign im_ack  = im_req && (age >= wait_states);
  assign im_data = im_ack ? mem_word(im_addr) : 32'hDEAD_BEEF;

  always @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      age       <= 0;
      ack_count <= 0;
    end else if (im_req && !im_ack) begin
      age <= age + 1;
    end else begin
      age <= 0;
      if (im_ack) ack_count <= ack_count + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Monitor: every accepted pop is compared in order against the scoreboard.
  always @(negedge clk) begin
    if (!rst_f && instr_valid && instr_ready && !redir) begin
      pop_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got pc %h expected no pop", instr_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pop_pc", {16'h0, instr_pc}, {16'h0, e.pc});
        check("pop_data", instr, e.data);
      end
    end
  end

  task automatic expect_pc(input logic [15:0] pc);
    exp_t e;
    e.pc   = pc;
    e.data = mem_word(pc);
    sb.push_back(e);
  endtask

  // Holds reset for two edges, then releases 1 time unit after an edge (cycle 0 starts there).
  task automatic do_reset(input int ws, input logic rdy, input bit check_idle);
    rst_f       = 1'b1;
    redir       = 1'b0;
    redir_addr  = 16'h0;
    wait_states = ws;
    instr_ready = rdy;
    repeat (2) @(posedge clk);
    #1;
    if (check_idle) begin
      check("rst_im_req", {31'h0, im_req}, 32'h0);
      check("rst_im_addr", {16'h0, im_addr}, 32'h0);
      check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_instr_pc", {16'h0, instr_pc}, 32'h0);
      check("rst_ifq_empty", {31'h0, ifq_empty}, 32'h1);
      check("rst_ifq_full", {31'h0, ifq_full}, 32'h0);
      check("rst_state", 32'(dut.state), 32'(IFQ_RUN));
    end
    rst_f = 1'b0;
  endtask

  task automatic end_test(input string name, input int target);
    int n = 0;
    @(posedge clk);
    #1;
    while (pop_count < target && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_pop_count"}, 32'(pop_count), 32'(target));
    check({name, "_sb_drained"}, 32'(sb.size()), 32'h0);
    sb.delete();
    rst_f = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    int n;

    // Zero-wait streaming: one fetch and one pop per cycle after a 1-cycle fill.
    base = pop_count;
    for (int k = 0; k < 7; k++) expect_pc(16'(k));
    do_reset(0, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("stream_im_req", {31'h0, im_req}, 32'h1);
      check("stream_im_addr", {16'h0, im_addr}, 32'(k));
      if (k == 0) check("stream_first_valid", {31'h0, instr_valid}, 32'h0);
    end
    end_test("stream", base + 7);

    // Consumer stalled: exactly four fills, then one pop re-opens a request at address 4.
    base = pop_count;
    expect_pc(16'h0000);
    do_reset(0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("full_ifq_full", {31'h0, ifq_full}, 32'h1);
    check("full_ifq_empty", {31'h0, ifq_empty}, 32'h0);
    check("full_im_req", {31'h0, im_req}, 32'h0);
    check("full_head_pc", {16'h0, instr_pc}, 32'h0);
    repeat (2) @(negedge clk);
    check("full_ack_count", 32'(ack_count), 32'h4);
    @(posedge clk);
    #1 instr_ready = 1'b1;
    @(posedge clk);
    #1 instr_ready = 1'b0;
    @(negedge clk);
    check("refill_im_req", {31'h0, im_req}, 32'h1);
    check("refill_im_addr", {16'h0, im_addr}, 32'h4);
    @(negedge clk);
    check("refill_full", {31'h0, ifq_full}, 32'h1);
    check("refill_head_pc", {16'h0, instr_pc}, 32'h1);
    end_test("full", base + 1);

    // Three wait states, redirect while 0x0005 is outstanding: drain, then fetch 0x0040.
    base = pop_count;
    for (int k = 0; k < 5; k++) expect_pc(16'(k));
    expect_pc(16'h0040);
    expect_pc(16'h0041);
    do_reset(3, 1'b1, 1'b0);
    n = 0;
    @(negedge clk);
    while (!(im_req && im_addr == 16'h0005) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_reached_5", {16'h0, im_addr}, 32'h5);
    @(posedge clk);
    #1 begin redir = 1'b1; redir_addr = 16'h0040; end
    @(posedge clk);
    #1 redir = 1'b0;
    @(negedge clk);
    check("drain_state", 32'(dut.state), 32'(IFQ_DRAIN));
    check("drain_im_req", {31'h0, im_req}, 32'h1);
    check("drain_im_addr", {16'h0, im_addr}, 32'h5);
    check("drain_valid", {31'h0, instr_valid}, 32'h0);
    n = 0;
    while (!im_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_next_addr", {16'h0, im_addr}, 32'h40);
    check("drain_back_run", 32'(dut.state), 32'(IFQ_RUN));
    end_test("drain", base + 7);

    // Redirect to 0xFFFE under continuous fetch: pc wraps with no side effect.
    base = pop_count;
    expect_pc(16'h0000);
    expect_pc(16'h0001);
    expect_pc(16'hFFFE);
    expect_pc(16'hFFFF);
    expect_pc(16'h0000);
    expect_pc(16'h0001);
    do_reset(0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1 begin redir = 1'b1; redir_addr = 16'hFFFE; end
    @(posedge clk);
    #1 redir = 1'b0;
    @(negedge clk);
    check("wrap_im_addr", {16'h0, im_addr}, 32'hFFFE);
    check("wrap_valid_low", {31'h0, instr_valid}, 32'h0);
    end_test("wrap", base + 6);

    // Redirect coinciding with an ack and a pop while two entries are queued.
    base = pop_count;
    expect_pc(16'h0100);
    expect_pc(16'h0101);
    do_reset(1, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("coll_two_head", {16'h0, instr_pc}, 32'h0);
    check("coll_two_valid", {31'h0, instr_valid}, 32'h1);
    @(posedge clk);
    #1 begin instr_ready = 1'b1; redir = 1'b1; redir_addr = 16'h0100; end
    @(negedge clk);
    check("coll_ack_present", {31'h0, im_ack}, 32'h1);
    @(posedge clk);
    #1 redir = 1'b0;
    @(negedge clk);
    check("coll_empty", {31'h0, ifq_empty}, 32'h1);
    check("coll_valid", {31'h0, instr_valid}, 32'h0);
    check("coll_im_addr", {16'h0, im_addr}, 32'h100);
    check("coll_state", 32'(dut.state), 32'(IFQ_RUN));
    end_test("coll", base + 2);

    // Asynchronous reset with three queued entries and a request outstanding.
    base = pop_count;
    do_reset(3, 1'b0, 1'b0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("pre_rst_valid", {31'h0, instr_valid}, 32'h1);
    check("pre_rst_im_addr", {16'h0, im_addr}, 32'h3);
    check("pre_rst_im_req", {31'h0, im_req}, 32'h1);
    @(posedge clk);
    #3 rst_f = 1'b1;
    #1;
    check("arst_im_req", {31'h0, im_req}, 32'h0);
    check("arst_im_addr", {16'h0, im_addr}, 32'h0);
    check("arst_valid", {31'h0, instr_valid}, 32'h0);
    check("arst_instr", instr, 32'h0);
    check("arst_instr_pc", {16'h0, instr_pc}, 32'h0);
    check("arst_empty", {31'h0, ifq_empty}, 32'h1);
    check("arst_full", {31'h0, ifq_full}, 32'h0);
    expect_pc(16'h0000);
    expect_pc(16'h0001);
    instr_ready = 1'b1;
    @(posedge clk);
    #1 rst_f = 1'b0;
    @(negedge clk);
    check("restart_im_req", {31'h0, im_req}, 32'h1);
    check("restart_im_addr", {16'h0, im_addr}, 32'h0);
    end_test("restart", base + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
